// File: rtl/number_accumulator.sv
// number_accumulator
//   Sums the masked-word stream into blocks of up to COUNT words and presents
//   each block's sum and word count on a registered valid/ready output.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   input word present
//   in_ready   out  block can accept a word this cycle
//   in_data    in   input word (unsigned, DATA_WIDTH)
//   in_last    in   closes the block early (qualified by in_valid & in_ready)
//   out_valid  out  out_sum/out_count hold a completed block
//   out_ready  in   downstream accepts the block
//   out_sum    out  sum of the block's words (OUT_WIDTH)
//   out_count  out  number of words in the block, 1..COUNT (CNT_WIDTH)
module number_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int COUNT      = 4,
  parameter int CNT_WIDTH  = $clog2(COUNT + 1),
  parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_sum,
  output logic [CNT_WIDTH-1:0]  out_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]   out_sum_q, out_sum_d;
  logic [CNT_WIDTH-1:0]   out_count_q, out_count_d;

  logic                   accept;
  logic [OUT_WIDTH-1:0]   sum_next;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic                   block_done;

  // Ready depends only on reset and state, never on in_valid.
  assign in_ready = rst_n & (state_q == ACCUM);
  assign accept   = in_valid & in_ready;

  // OUT_WIDTH exceeds DATA_WIDTH by clog2(COUNT) >= 1 bits, so the
  // zero-extension is never empty and the sum cannot overflow.
  assign sum_next   = acc_q + {{(OUT_WIDTH - DATA_WIDTH){1'b0}}, in_data};
  assign cnt_inc    = cnt_q + CNT_WIDTH'(1);
  assign block_done = (cnt_inc == CNT_WIDTH'(COUNT)) | in_last;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;

    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (block_done) begin
            out_sum_d   = sum_next;
            out_count_d = cnt_inc;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            acc_d = sum_next;
            cnt_d = cnt_inc;
          end
        end
      end
      HOLD: begin
        // Result stays frozen until downstream takes it; sum/count keep
        // their values afterwards (don't-care while out_valid is low).
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_number_accumulator.sv
// tb_number_accumulator
//   Directed and randomised stimulus for number_accumulator. The driver pushes
//   expected block results into a queue; an independent monitor pops and
//   compares whenever a block is handed off downstream.
module tb_number_accumulator;

  localparam int DW = 16;
  localparam int CN = 4;
  localparam int CW = 3;
  localparam int OW = 18;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_sum;
  logic [CW-1:0] out_count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [OW-1:0] sum;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  bit   rand_or = 1'b0;
  int   blocks_seen = 0;

  number_accumulator #(
    .DATA_WIDTH(DW),
    .COUNT     (CN),
    .CNT_WIDTH (CW),
    .OUT_WIDTH (OW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Offer one word and return 1 ns after the edge on which it was accepted.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int  n = 0;
    bit  done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else if (++n > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: word 0x%0h not accepted within 200 cycles", d);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [OW-1:0] s, input logic [CW-1:0] c);
    exp_t e;
    e.sum = s;
    e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Random backpressure, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_or) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: handshake checks against the scoreboard, plus stability of the
  // held result while downstream stalls.
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_sum;
  logic [CW-1:0] prev_cnt;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && prev_stall) begin
      checks++;
      if (!out_valid || out_sum !== prev_sum || out_count !== prev_cnt) begin
        failures++;
        $display("FAIL hold_stable: got v=%0b sum=0x%0h cnt=%0d expected v=1 sum=0x%0h cnt=%0d",
                 out_valid, out_sum, out_count, prev_sum, prev_cnt);
      end
    end
    prev_stall = rst_n && out_valid && !out_ready;
    prev_sum   = out_sum;
    prev_cnt   = out_count;
    if (rst_n && out_valid && out_ready) begin
      blocks_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got sum=0x%0h cnt=%0d expected no block", out_sum, out_count);
      end else begin
        e = exp_q.pop_front();
        chk("blk_sum", 32'(out_sum), 32'(e.sum));
        chk("blk_cnt", 32'(out_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    logic [OW-1:0] s;
    int            len;
    logic          l;
    int            n;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    cycle(); cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_in_ready_rel", 32'(in_ready), 32'd1);
    cycle();

    // 1: four consecutive words, one-cycle valid pulse, single bubble.
    send(16'h0001, 1'b0); send(16'h0002, 1'b0); send(16'h0003, 1'b0); send(16'h0004, 1'b0);
    push(18'h0000A, 3'd4);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid_on", 32'(out_valid), 32'd1);
    chk("t1_ready_off", 32'(in_ready), 32'd0);
    cycle();
    @(negedge clk);
    chk("t1_valid_off", 32'(out_valid), 32'd0);
    chk("t1_ready_on", 32'(in_ready), 32'd1);
    cycle();

    // 2: full-scale words use the whole 18-bit width.
    for (int i = 0; i < 4; i++) send(16'hFFFF, 1'b0);
    push(18'h3FFFC, 3'd4);
    in_valid = 1'b0;

    // 3: early close with downstream stalled; offered word must wait.
    cycle(); cycle();
    out_ready = 1'b0;
    send(16'h00FF, 1'b0); send(16'h0F00, 1'b1);
    push(18'h00FFF, 3'd2);
    in_valid = 1'b1; in_data = 16'h1111; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_valid_held", 32'(out_valid), 32'd1);
      chk("t3_ready_low", 32'(in_ready), 32'd0);
      chk("t3_sum_held", 32'(out_sum), 32'h00FFF);
      cycle();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    cycle();
    @(negedge clk);
    chk("t3_ready_after", 32'(in_ready), 32'd1);
    chk("t3_valid_after", 32'(out_valid), 32'd0);
    cycle();

    // 4: in_last on the first word.
    send(16'h1234, 1'b1);
    push(18'h01234, 3'd1);
    in_valid = 1'b0;

    // 5: reset mid-block discards the partial sum.
    cycle();
    send(16'h0010, 1'b0); send(16'h0020, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_ready_in_rst", 32'(in_ready), 32'd0);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(16'h0005, 1'b0);
    push(18'h00014, 3'd4);
    in_valid = 1'b0;

    // 6: random gaps, lengths and backpressure.
    rand_or = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      len = $urandom_range(1, CN);
      s = '0;
      for (int w = 0; w < len; w++) begin
        n = $urandom_range(0, 2);
        if (n != 0) begin
          in_valid = 1'b0;
          repeat (n) cycle();
        end
        d = DW'($urandom);
        l = (w == len - 1) && ((len < CN) || ($urandom_range(0, 1) == 1));
        s = s + OW'(d);
        send(d, l);
      end
      push(s, CW'(len));
    end
    in_valid = 1'b0;
    rand_or = 1'b0;
    out_ready = 1'b1;

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cycle();
      n++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("blocks_seen", 32'(blocks_seen), 32'd1005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/number_accumulator.md
Name: number_accumulator

Overview:
- Downstream stage for the 16-bit masked-word path: it consumes the AND-combined word stream (out_num = in_b & in_c) produced by the number-test datapath.
- Sums up to COUNT words per block using a valid/ready handshake.
- Presents each block's sum, plus the number of words it contains, on a registered valid/ready output.
- Sits between the combinational number logic and the register/trace sink.

Parameters:
- DATA_WIDTH, 16, width of each input word (unsigned).
- COUNT, 4, maximum words per block; must be ≥ 2.
- CNT_WIDTH, clog2(COUNT+1) = 3, width of the word counter and out_count.
- OUT_WIDTH, DATA_WIDTH + clog2(COUNT) = 18, width of the sum; sized so it cannot overflow.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  DATA_WIDTH  input word (unsigned).
- in_last  in  1  this word closes the block early; qualified by in_valid & in_ready.
- out_valid  out  1  out_sum/out_count hold a completed block.
- out_ready  in  1  downstream accepts the block.
- out_sum  out  OUT_WIDTH  sum of the block's words.
- out_count  out  CNT_WIDTH  number of words in the block (1..COUNT).

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. Sampling rst_n=0 on a rising edge forces:
  - state=ACCUM, acc=0, cnt=0
  - out_valid=0, out_sum=0, out_count=0
- in_ready is 0 while rst_n=0; that cycle's input is ignored.
- Reset mid-block or mid-HOLD discards all partial or pending data; no output is produced for it.
- States: ACCUM, HOLD.
- in_ready = rst_n & (state==ACCUM). This is combinational from state only and never depends on in_valid.
- Accept = in_valid & in_ready.
- ACCUM, accept, with (cnt+1 < COUNT) and in_last=0:
  - acc <= acc + zero_extend(in_data); cnt <= cnt+1; stay in ACCUM.
- ACCUM, accept, with (cnt+1 == COUNT) or in_last=1:
  - out_sum <= acc + zero_extend(in_data); out_count <= cnt+1; out_valid <= 1.
  - acc <= 0; cnt <= 0; go to HOLD.
  - Latency: the result is visible on the cycle after the closing beat.
- ACCUM, no accept: all state is held.
- HOLD:
  - in_ready=0.
  - out_sum, out_count and out_valid are stable until the handshake.
  - out_valid & out_ready: out_valid <= 0, go to ACCUM. out_sum and out_count keep their last values; they are don't-care while out_valid=0.
- Throughput: with out_ready tied high, a COUNT-word block occupies COUNT+1 cycles (one bubble per block). This is intentional; there is no ACCUM/HOLD overlap.
- in_last on the first word produces a block with out_count=1.
- in_last on word COUNT is the same as a normal full block.
- in_last is ignored when there is no accept.
- Arithmetic: unsigned, zero-extended to OUT_WIDTH, no saturation. The maximum sum is COUNT*(2^DATA_WIDTH − 1), which fits.
- out_ready asserted while out_valid=0 has no effect.
- The output contains no X: every output has a defined reset value.

Test Plan:
1. Reset, then in_valid=1 with words 0x0001, 0x0002, 0x0003, 0x0004, out_ready=1 -> out_valid=1 for one cycle, the cycle after the 4th accept; out_sum=0x0000A, out_count=4; in_ready=0 exactly on that cycle.
2. Four words of 0xFFFF -> out_sum=0x3FFFC, out_count=4 (no overflow; full 18-bit width used).
3. Words 0x00FF, 0x0F00 with in_last=1 on the second, out_ready=0 for 5 cycles -> out_valid stays 1 with out_sum=0x00FFF and out_count=2 stable throughout; in_ready=0 throughout; the word offered during HOLD is not consumed. Raising out_ready -> handshake, and in_ready=1 the next cycle.
4. in_last=1 on the first word 0x1234 -> out_sum=0x01234, out_count=1.
5. Accept 2 words (0x0010, 0x0020), pull rst_n=0 for one cycle, then send 0x0005 ×4 -> out_sum=0x00014, out_count=4. No residue from the aborted block, and no output for it.
6. Random in_valid/out_ready toggling over 1000 blocks against a scoreboard -> every sum and count matches; no word is lost or duplicated; out_* never changes while out_valid & !out_ready.
